rca_instruction_unit: RTL and testbench

Responder side of the RCA custom-instruction interface: accepts RCA-opcode instructions issued by the core, decodes fn7/fn3, and serialises config writes to the reconfigurable accelerator.
USE operations launch the accelerator and return its result on a writeback handshake.
Sits between the issue stage and the RCA grid as one execution unit; one instruction in flight at a time.

---
 rtl/rca_instruction_unit_pkg.sv | 47 ++++
 rtl/rca_instruction_unit_decode.sv | 34 +++
 rtl/rca_instruction_unit.sv | 182 ++++++++++++++++++
 tb/tb_rca_instruction_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_instruction_unit_pkg.sv
// Shared types and constants for the RCA custom-instruction execution unit.
package rca_instruction_unit_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned FN3_W      = 3;
  localparam int unsigned CFG_DATA_W = 2 * XLEN;

  localparam logic [6:0]      OPCODE_RCA       = 7'b0101011;
  localparam logic [XLEN-1:0] RCA_TIMEOUT_DATA = 32'hFFFF_FFFF;

  typedef enum logic [6:0] {
    RCA_FN7 = 7'b1000000
  } rca_fn7_t;

  typedef enum logic [FN3_W-1:0] {
    FN3_USE            = 3'b000,
    FN3_CPU_REG_CONFIG = 3'b001,
    FN3_CFG_2          = 3'b010,
    FN3_CFG_3          = 3'b011,
    FN3_CFG_4          = 3'b100,
    FN3_CFG_5          = 3'b101
  } rca_fn3_t;

  typedef enum logic [1:0] {
    OP_ILLEGAL = 2'd0,
    OP_USE     = 2'd1,
    OP_CONFIG  = 2'd2
  } rca_op_class_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CFG_REQ   = 3'd1,
    ST_USE_START = 3'd2,
    ST_USE_WAIT  = 3'd3,
    ST_WB        = 3'd4
  } rca_unit_state_t;

  // Config write payload presented to the accelerator.
  typedef struct packed {
    logic [FN3_W-1:0]      sel;
    logic [REG_ADDR_W-1:0] addr;
    logic [CFG_DATA_W-1:0] data;
  } rca_cfg_req_t;

endpackage

// File: rtl/rca_instruction_unit_decode.sv
// Combinational RCA instruction legality check and op-class decode.
module rca_decode
  import rca_instruction_unit_pkg::*;
(
  input  logic [INSTR_W-1:0]    i_instr,
  output rca_op_class_t         o_class_c,
  output logic [FN3_W-1:0]      o_fn3_c,
  output logic [REG_ADDR_W-1:0] o_rd_c
);

  logic [6:0] w_opcode;
  logic [6:0] w_fn7;
  logic       w_unused;

  assign w_opcode = i_instr[6:0];
  assign w_fn7    = i_instr[31:25];
  assign o_fn3_c  = i_instr[14:12];
  assign o_rd_c   = i_instr[11:7];
  // Source register fields are not needed: operand values arrive pre-read.
  assign w_unused = ^i_instr[24:15];

  // Classify: right opcode and fn7, then fn3 selects USE or one of five config ops.
  always_comb begin
    o_class_c = OP_ILLEGAL;
    if ((w_opcode == OPCODE_RCA) && (w_fn7 == RCA_FN7)) begin
      if (o_fn3_c == FN3_USE) begin
        o_class_c = OP_USE;
      end else if (o_fn3_c <= FN3_CFG_5) begin
        o_class_c = OP_CONFIG;
      end
    end
  end

endmodule

// File: rtl/rca_instruction_unit.sv
// RCA custom-instruction responder: config write serialiser and USE launch/writeback.
module rca_instruction_unit
  import rca_instruction_unit_pkg::*;
#(
  parameter int unsigned ID_W           = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [INSTR_W-1:0]    issue_instr,
  input  logic [XLEN-1:0]       issue_rs1,
  input  logic [XLEN-1:0]       issue_rs2,
  input  logic [ID_W-1:0]       issue_id,
  output logic                  cfg_valid,
  input  logic                  cfg_ready,
  output logic [FN3_W-1:0]      cfg_sel,
  output logic [REG_ADDR_W-1:0] cfg_addr,
  output logic [CFG_DATA_W-1:0] cfg_data,
  output logic                  acc_start,
  output logic [XLEN-1:0]       acc_rs1,
  output logic [XLEN-1:0]       acc_rs2,
  input  logic                  acc_done,
  input  logic [XLEN-1:0]       acc_result,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [ID_W-1:0]       wb_id,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic                  illegal,
  output logic                  timeout,
  output logic                  busy
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  rca_unit_state_t       r_state;
  rca_unit_state_t       w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  rca_cfg_req_t          r_cfg;
  logic [XLEN-1:0]       r_rs1;
  logic [XLEN-1:0]       r_rs2;
  logic [ID_W-1:0]       r_id;
  logic [XLEN-1:0]       r_wb_data;
  logic                  r_issue_ready;
  logic                  r_busy;
  logic                  r_cfg_valid;
  logic                  r_acc_start;
  logic                  r_wb_valid;
  logic                  r_illegal;
  rca_op_class_t         w_class;
  logic [FN3_W-1:0]      w_fn3;
  logic [REG_ADDR_W-1:0] w_rd;
  logic                  w_accept;
  logic                  w_load_result;
  logic                  w_timeout;

  rca_decode u_decode (
    .i_instr   (issue_instr),
    .o_class_c (w_class),
    .o_fn3_c   (w_fn3),
    .o_rd_c    (w_rd)
  );

  assign w_accept = issue_valid & r_issue_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; acc_done only counts in USE_WAIT and beats the terminal count.
  always_comb begin
    w_state_nxt   = r_state;
    w_load_result = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_class == OP_USE) begin
            w_state_nxt = ST_USE_START;
          end else if (w_class == OP_CONFIG) begin
            w_state_nxt = ST_CFG_REQ;
          end
        end
      end
      ST_CFG_REQ: begin
        if (cfg_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_USE_START: begin
        w_state_nxt = ST_USE_WAIT;
      end
      ST_USE_WAIT: begin
        if (acc_done || (r_cnt == CNT_LAST)) begin
          w_load_result = 1'b1;
          w_timeout     = ~acc_done;
          w_state_nxt   = (r_cfg.addr == '0) ? ST_IDLE : ST_WB;
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Wait counter: held at zero outside USE_WAIT so every wait starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state != ST_USE_WAIT) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Registered handshake flags and payloads, derived from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_ready <= 1'b1;
      r_busy        <= 1'b0;
      r_cfg_valid   <= 1'b0;
      r_acc_start   <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_illegal     <= 1'b0;
      r_cfg         <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_id          <= '0;
      r_wb_data     <= '0;
    end else begin
      r_issue_ready <= (w_state_nxt == ST_IDLE);
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_cfg_valid   <= (w_state_nxt == ST_CFG_REQ);
      r_acc_start   <= (w_state_nxt == ST_USE_START);
      r_wb_valid    <= (w_state_nxt == ST_WB);
      r_illegal     <= w_accept & (w_class == OP_ILLEGAL);
      if (w_accept && (w_class != OP_ILLEGAL)) begin
        r_cfg.sel  <= w_fn3;
        r_cfg.addr <= w_rd;
        r_cfg.data <= {issue_rs2, issue_rs1};
        r_rs1      <= issue_rs1;
        r_rs2      <= issue_rs2;
        r_id       <= issue_id;
      end
      if (w_load_result) begin
        r_wb_data <= w_timeout ? RCA_TIMEOUT_DATA : acc_result;
      end
    end
  end

  assign issue_ready = r_issue_ready;
  assign busy        = r_busy;
  assign cfg_valid   = r_cfg_valid;
  assign cfg_sel     = r_cfg.sel;
  assign cfg_addr    = r_cfg.addr;
  assign cfg_data    = r_cfg.data;
  assign acc_start   = r_acc_start;
  assign acc_rs1     = r_rs1;
  assign acc_rs2     = r_rs2;
  assign wb_valid    = r_wb_valid;
  assign wb_id       = r_id;
  assign wb_rd       = r_cfg.addr;
  assign wb_data     = r_wb_data;
  assign illegal     = r_illegal;
  // Timeout flags the terminal-count cycle itself, so it follows acc_done directly.
  assign timeout     = w_timeout;

endmodule

// File: tb/tb_rca_instruction_unit.sv
// Directed + randomized bench for rca_instruction_unit against a field-level model.
module tb_rca_instruction_unit;

  localparam int unsigned TC = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_instr;
  logic [31:0] issue_rs1;
  logic [31:0] issue_rs2;
  logic [2:0]  issue_id;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_sel;
  logic [4:0]  cfg_addr;
  logic [63:0] cfg_data;
  logic        acc_start;
  logic [31:0] acc_rs1;
  logic [31:0] acc_rs2;
  logic        acc_done;
  logic [31:0] acc_result;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_id;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;
  logic        timeout;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  rca_instruction_unit #(.ID_W(3), .TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_id(issue_id),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .acc_start(acc_start), .acc_rs1(acc_rs1), .acc_rs2(acc_rs2),
    .acc_done(acc_done), .acc_result(acc_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_id(wb_id), .wb_rd(wb_rd),
    .wb_data(wb_data), .illegal(illegal), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: 0 illegal, 1 USE, 2 config.
  function automatic int classify(input logic [31:0] w);
    int opc, f3, f7;
    opc = int'(w & 32'h7F);
    f3  = int'((w >> 12) & 32'h7);
    f7  = int'((w >> 25) & 32'h7F);
    if (opc != 'h2B || f7 != 'h40 || f3 > 5) return 0;
    return (f3 == 0) ? 1 : 2;
  endfunction

  function automatic logic [31:0] make_instr(input int f7, input int f3, input int rd, input int opc);
    logic [31:0] w;
    w = (32'(f7) << 25) + (32'($urandom_range(0, 1023)) << 15) + (32'(f3) << 12)
      + (32'(rd) << 7) + 32'(opc);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] id);
    int guard;
    guard = 0;
    while (issue_ready !== 1'b1 && guard < 64) begin
      tick();
      guard++;
    end
    chk("issue_ready_idle", 64'(issue_ready), 64'd1);
    issue_valid = 1'b1;
    issue_instr = instr;
    issue_rs1   = a;
    issue_rs2   = b;
    issue_id    = id;
    tick();
    issue_valid = 1'b0;
    issue_instr = $urandom;
    issue_rs1   = $urandom;
    issue_rs2   = $urandom;
    issue_id    = 3'($urandom);
  endtask

  task automatic do_illegal(input logic [31:0] instr);
    issue(instr, $urandom, $urandom, 3'($urandom));
    chk("ill_pulse", 64'(illegal), 64'd1);
    chk("ill_ready", 64'(issue_ready), 64'd1);
    chk("ill_busy", 64'(busy), 64'd0);
    chk("ill_cfg", 64'(cfg_valid), 64'd0);
    chk("ill_acc", 64'(acc_start), 64'd0);
    chk("ill_wb", 64'(wb_valid), 64'd0);
  endtask

  task automatic do_cfg(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] id, input int delay);
    logic [2:0]  e_sel;
    logic [4:0]  e_addr;
    logic [63:0] e_data;
    e_sel  = 3'((instr >> 12) & 32'h7);
    e_addr = 5'((instr >> 7) & 32'h1F);
    e_data = (64'(b) << 32) + 64'(a);
    cfg_ready = (delay == 0);
    issue(instr, a, b, id);
    chk("cfg_no_illegal", 64'(illegal), 64'd0);
    for (int i = 0; i <= delay; i++) begin
      chk("cfg_valid", 64'(cfg_valid), 64'd1);
      chk("cfg_sel", 64'(cfg_sel), 64'(e_sel));
      chk("cfg_addr", 64'(cfg_addr), 64'(e_addr));
      chk("cfg_data", cfg_data, e_data);
      chk("cfg_busy", 64'(busy), 64'd1);
      chk("cfg_not_ready", 64'(issue_ready), 64'd0);
      chk("cfg_no_acc", 64'(acc_start), 64'd0);
      chk("cfg_no_wb", 64'(wb_valid), 64'd0);
      cfg_ready = (i == delay);
      tick();
    end
    cfg_ready = 1'b0;
    chk("cfg_done_valid", 64'(cfg_valid), 64'd0);
    chk("cfg_done_ready", 64'(issue_ready), 64'd1);
    chk("cfg_done_busy", 64'(busy), 64'd0);
    chk("cfg_done_wb", 64'(wb_valid), 64'd0);
  endtask

  // k: wait-cycle index at which acc_done arrives (>= TC means never).
  task automatic do_use(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] id, input int k, input logic [31:0] res,
                        input int stall, input logic noise);
    logic [4:0]  rd;
    logic [31:0] e_data;
    rd     = 5'((instr >> 7) & 32'h1F);
    e_data = 32'hFFFF_FFFF;
    issue(instr, a, b, id);
    chk("use_no_illegal", 64'(illegal), 64'd0);
    chk("use_start", 64'(acc_start), 64'd1);
    chk("use_rs1", 64'(acc_rs1), 64'(a));
    chk("use_rs2", 64'(acc_rs2), 64'(b));
    chk("use_busy", 64'(busy), 64'd1);
    chk("use_not_ready", 64'(issue_ready), 64'd0);
    chk("use_no_cfg", 64'(cfg_valid), 64'd0);
    acc_done   = noise;
    acc_result = 32'h0BAD_0BAD;
    tick();
    chk("use_start_once", 64'(acc_start), 64'd0);
    for (int i = 0; i < int'(TC); i++) begin
      acc_done   = (i == k);
      acc_result = (i == k) ? res : $urandom;
      #1;
      chk("use_timeout", 64'(timeout), 64'((i == int'(TC) - 1) && (i != k)));
      chk("use_wait_wb", 64'(wb_valid), 64'd0);
      chk("use_wait_busy", 64'(busy), 64'd1);
      if (i == k) e_data = res;
      tick();
      acc_done = 1'b0;
      if (i == k) break;
    end
    if (rd == 5'd0) begin
      chk("rd0_no_wb", 64'(wb_valid), 64'd0);
      chk("rd0_busy", 64'(busy), 64'd0);
      chk("rd0_ready", 64'(issue_ready), 64'd1);
      chk("rd0_timeout", 64'(timeout), 64'd0);
    end else begin
      for (int j = 0; j <= stall; j++) begin
        chk("wb_valid", 64'(wb_valid), 64'd1);
        chk("wb_id", 64'(wb_id), 64'(id));
        chk("wb_rd", 64'(wb_rd), 64'(rd));
        chk("wb_data", 64'(wb_data), 64'(e_data));
        chk("wb_busy", 64'(busy), 64'd1);
        chk("wb_not_ready", 64'(issue_ready), 64'd0);
        chk("wb_timeout", 64'(timeout), 64'd0);
        wb_ready   = (j == stall);
        acc_done   = noise;
        acc_result = $urandom;
        tick();
      end
      wb_ready = 1'b0;
      acc_done = 1'b0;
      chk("wb_done_valid", 64'(wb_valid), 64'd0);
      chk("wb_done_ready", 64'(issue_ready), 64'd1);
      chk("wb_done_busy", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] instr;
    int          kind;
    rst_n       = 1'b0;
    issue_valid = 1'b0;
    issue_instr = '0;
    issue_rs1   = '0;
    issue_rs2   = '0;
    issue_id    = '0;
    cfg_ready   = 1'b0;
    acc_done    = 1'b0;
    acc_result  = '0;
    wb_ready    = 1'b0;

    // Reset state.
    #12;
    chk("rst_ready", 64'(issue_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cfg", 64'(cfg_valid), 64'd0);
    chk("rst_acc", 64'(acc_start), 64'd0);
    chk("rst_wb", 64'(wb_valid), 64'd0);
    chk("rst_ill", 64'(illegal), 64'd0);
    chk("rst_to", 64'(timeout), 64'd0);
    chk("rst_wbdata", 64'(wb_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // CPU_REG_CONFIG, ready tied high.
    do_cfg(32'h8000_102B, 32'h11, 32'h22, 3'd0, 0);

    // USE rd=5 id=3, done 4 cycles after start, writeback stalled 2 cycles.
    do_use(32'h8000_02AB, 32'hA5A5_0001, 32'h5A5A_0002, 3'd3, 3, 32'hDEAD_BEEF, 2, 1'b0);

    // Illegal fn3=110, then illegal fn7=0 accepted at T+1, then a config op.
    do_illegal(32'h8000_602B);
    do_illegal(32'h0000_002B);
    do_cfg(make_instr('h40, 5, 9, 'h2B), 32'h1, 32'h2, 3'd1, 2);

    // Timeout, with late acc_done during WB and in IDLE.
    do_use(make_instr('h40, 0, 7, 'h2B), 32'h3, 32'h4, 3'd6, 100, 32'h0, 1, 1'b1);
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    chk("late_done_busy", 64'(busy), 64'd0);
    chk("late_done_wb", 64'(wb_valid), 64'd0);
    chk("late_done_acc", 64'(acc_start), 64'd0);

    // Done on the final count: normal result, no timeout.
    do_use(make_instr('h40, 0, 12, 'h2B), 32'h5, 32'h6, 3'd2, int'(TC) - 1, 32'h1234_5678, 0, 1'b0);

    // rd=0 USE: no writeback.
    do_use(32'h8000_002B, 32'h7, 32'h8, 3'd4, 2, 32'hCAFE_F00D, 0, 1'b0);

    // Asynchronous reset while a config write is stalled.
    cfg_ready = 1'b0;
    issue(32'h8000_302B, 32'h99, 32'h98, 3'd5);
    chk("pre_rst_cfg", 64'(cfg_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cfg", 64'(cfg_valid), 64'd0);
    chk("async_rst_ready", 64'(issue_ready), 64'd1);
    chk("async_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_cfg(32'h8000_202B, 32'hAA, 32'hBB, 3'd7, 1);

    // Randomized mix against the model.
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      if (kind == 0) begin
        instr = make_instr('h40, 0, int'($urandom_range(0, 31)), 'h2B);
      end else if (kind == 1) begin
        instr = make_instr('h40, int'($urandom_range(1, 5)), int'($urandom_range(0, 31)), 'h2B);
      end else begin
        case ($urandom_range(0, 2))
          0: instr = make_instr('h40, int'($urandom_range(6, 7)), 3, 'h2B);
          1: instr = make_instr(int'($urandom_range(0, 63)), 0, 3, 'h2B);
          default: instr = make_instr('h40, 1, 3, ($urandom_range(0, 1) == 0) ? 'h33 : 'h2F);
        endcase
      end
      case (classify(instr))
        1: do_use(instr, $urandom, $urandom, 3'($urandom), int'($urandom_range(0, 10)),
                  $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        2: do_cfg(instr, $urandom, $urandom, 3'($urandom), int'($urandom_range(0, 3)));
        default: do_illegal(instr);
      endcase
    end
    do_cfg(32'h8000_502B, 32'h1234, 32'h5678, 3'd2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
